// File: rtl/apb_master_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : apb_arb_pkg
// Description : Shared constants for the APB master arbiter (FSM encoding,
//               slave-select decode field, timeout counter width).
// Revision    : 1.0 - initial release
// ============================================================================
package apb_arb_pkg;

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_SETUP  = 2'd1;
    localparam logic [1:0] c_ST_ACCESS = 2'd2;

    localparam int APB_SEL_W = 16;
    localparam int SEL_LSB   = 24;
    localparam int SEL_MSB   = 27;
    localparam int CNT_W     = 16;

endpackage
`default_nettype wire

// File: rtl/apb_master_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin picker; searches upward from
//               i_last+1 (mod NREQ) for the first active request.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NREQ  = 4,
    parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  i_req,
    input  logic [IDX_W-1:0] i_last,
    output logic [NREQ-1:0]  o_gnt,
    output logic [IDX_W-1:0] o_idx
);

    int   w_last;
    logic w_found;

    // Two ascending passes: indices above i_last first, then the wrap-around.
    always_comb begin
        w_last  = int'(i_last);
        w_found = 1'b0;
        o_gnt   = '0;
        o_idx   = '0;
        for (int j = 0; j < NREQ; j++) begin
            if (!w_found && i_req[j] && (j > w_last)) begin
                w_found  = 1'b1;
                o_gnt[j] = 1'b1;
                o_idx    = IDX_W'(j);
            end
        end
        for (int j = 0; j < NREQ; j++) begin
            if (!w_found && i_req[j] && (j <= w_last)) begin
                w_found  = 1'b1;
                o_gnt[j] = 1'b1;
                o_idx    = IDX_W'(j);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/apb_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : apb_master_arbiter
// Description : Round-robin sharing of one APB3 master port between NREQ
//               requesters, with slave-select decode and ACCESS timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_master_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 256
) (
    input  logic                 PCLK,
    input  logic                 PRESET,
    input  logic [NREQ-1:0]      REQ,
    input  logic [32*NREQ-1:0]   REQ_ADDR,
    input  logic [NREQ-1:0]      REQ_WRITE,
    input  logic [32*NREQ-1:0]   REQ_WDATA,
    output logic [NREQ-1:0]      GNT,
    output logic [NREQ-1:0]      DONE,
    output logic [31:0]          RDATA,
    output logic                 SLVERR,
    output logic                 TOUT,
    output logic [APB_SEL_W-1:0] PSEL,
    output logic [31:0]          PADDR,
    output logic                 PWRITE,
    output logic                 PENABLE,
    output logic [31:0]          PWDATA,
    input  logic [31:0]          PRDATA,
    input  logic                 PREADY,
    input  logic                 PSLVERR
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [CNT_W-1:0] c_TO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    logic [1:0]           r_state;
    logic [IDX_W-1:0]     r_last;
    logic [CNT_W-1:0]     r_cnt;
    logic [NREQ-1:0]      r_gnt;
    logic [NREQ-1:0]      r_done;
    logic [31:0]          r_rdata;
    logic                 r_slverr;
    logic                 r_tout;
    logic [APB_SEL_W-1:0] r_psel;
    logic [31:0]          r_paddr;
    logic                 r_pwrite;
    logic                 r_penable;
    logic [31:0]          r_pwdata;

    logic [NREQ-1:0]      w_elig;
    logic [NREQ-1:0]      w_win;
    logic [IDX_W-1:0]     w_win_idx;
    logic [31:0]          w_sel_addr;
    logic [31:0]          w_sel_wdata;
    logic                 w_sel_write;

    // A requester still holding REQ during its own DONE cycle must not win again.
    assign w_elig = REQ & ~r_done;

    rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .i_req  (w_elig),
        .i_last (r_last),
        .o_gnt  (w_win),
        .o_idx  (w_win_idx)
    );

    always_comb begin
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        w_sel_write = 1'b0;
        for (int j = 0; j < NREQ; j++) begin
            if (w_win[j]) begin
                w_sel_addr  = REQ_ADDR[32*j +: 32];
                w_sel_wdata = REQ_WDATA[32*j +: 32];
                w_sel_write = REQ_WRITE[j];
            end
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state   <= c_ST_IDLE;
            r_last    <= IDX_W'(NREQ - 1);
            r_cnt     <= '0;
            r_gnt     <= '0;
            r_done    <= '0;
            r_rdata   <= '0;
            r_slverr  <= 1'b0;
            r_tout    <= 1'b0;
            r_psel    <= '0;
            r_paddr   <= '0;
            r_pwrite  <= 1'b0;
            r_penable <= 1'b0;
            r_pwdata  <= '0;
        end else begin
            r_done <= '0;
            case (r_state)
                c_ST_IDLE: begin
                    r_gnt <= '0;
                    if (|w_elig) begin
                        r_state  <= c_ST_SETUP;
                        r_gnt    <= w_win;
                        r_last   <= w_win_idx;
                        r_paddr  <= w_sel_addr;
                        r_pwrite <= w_sel_write;
                        r_pwdata <= w_sel_wdata;
                        r_psel   <= APB_SEL_W'(1) << w_sel_addr[SEL_MSB:SEL_LSB];
                    end
                end
                c_ST_SETUP: begin
                    r_state   <= c_ST_ACCESS;
                    r_penable <= 1'b1;
                    r_cnt     <= '0;
                end
                c_ST_ACCESS: begin
                    if (PREADY) begin
                        r_state   <= c_ST_IDLE;
                        r_done    <= r_gnt;
                        r_rdata   <= r_pwrite ? 32'd0 : PRDATA;
                        r_slverr  <= PSLVERR;
                        r_tout    <= 1'b0;
                        r_psel    <= '0;
                        r_penable <= 1'b0;
                        r_paddr   <= '0;
                        r_pwdata  <= '0;
                    end else if ((TIMEOUT != 0) && (r_cnt == c_TO_LAST)) begin
                        r_state   <= c_ST_IDLE;
                        r_done    <= r_gnt;
                        r_rdata   <= '0;
                        r_slverr  <= 1'b1;
                        r_tout    <= 1'b1;
                        r_psel    <= '0;
                        r_penable <= 1'b0;
                        r_paddr   <= '0;
                        r_pwdata  <= '0;
                        r_pwrite  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign GNT     = r_gnt;
    assign DONE    = r_done;
    assign RDATA   = r_rdata;
    assign SLVERR  = r_slverr;
    assign TOUT    = r_tout;
    assign PSEL    = r_psel;
    assign PADDR   = r_paddr;
    assign PWRITE  = r_pwrite;
    assign PENABLE = r_penable;
    assign PWDATA  = r_pwdata;

endmodule
`default_nettype wire

// File: tb/tb_apb_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_master_arbiter
// Description : Directed plus randomized bench for apb_master_arbiter with a
//               transaction-level reference model checked every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_master_arbiter;

    localparam int NREQ    = 4;
    localparam int TIMEOUT = 8;

    logic                 PCLK;
    logic                 PRESET;
    logic [NREQ-1:0]      REQ;
    logic [32*NREQ-1:0]   REQ_ADDR;
    logic [NREQ-1:0]      REQ_WRITE;
    logic [32*NREQ-1:0]   REQ_WDATA;
    logic [NREQ-1:0]      GNT;
    logic [NREQ-1:0]      DONE;
    logic [31:0]          RDATA;
    logic                 SLVERR;
    logic                 TOUT;
    logic [15:0]          PSEL;
    logic [31:0]          PADDR;
    logic                 PWRITE;
    logic                 PENABLE;
    logic [31:0]          PWDATA;
    logic [31:0]          PRDATA;
    logic                 PREADY;
    logic                 PSLVERR;

    logic [31:0] a_addr  [NREQ];
    logic [31:0] a_wdata [NREQ];

    int total = 0;
    int bad   = 0;

    apb_master_arbiter #(
        .NREQ    (NREQ),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .REQ       (REQ),
        .REQ_ADDR  (REQ_ADDR),
        .REQ_WRITE (REQ_WRITE),
        .REQ_WDATA (REQ_WDATA),
        .GNT       (GNT),
        .DONE      (DONE),
        .RDATA     (RDATA),
        .SLVERR    (SLVERR),
        .TOUT      (TOUT),
        .PSEL      (PSEL),
        .PADDR     (PADDR),
        .PWRITE    (PWRITE),
        .PENABLE   (PENABLE),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    always_comb begin
        REQ_ADDR  = '0;
        REQ_WDATA = '0;
        for (int j = 0; j < NREQ; j++) begin
            REQ_ADDR[32*j +: 32]  = a_addr[j];
            REQ_WDATA[32*j +: 32] = a_wdata[j];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", nm, $time, act, exp);
        end
    endtask

    function automatic int oh_idx(input logic [NREQ-1:0] v);
        for (int i = 0; i < NREQ; i++) if (v[i]) return i;
        return -1;
    endfunction

    // ------------------------------------------------------------------
    // Reference model: a transaction is owned by one requester and has an
    // age (0 = setup cycle, k = k-th access cycle). Outputs follow from that.
    // ------------------------------------------------------------------
    typedef struct packed {
        int              owner;
        int              age;
        int              last;
        logic [NREQ-1:0] gnt;
        logic [NREQ-1:0] done;
        logic [15:0]     psel;
        logic [31:0]     paddr;
        logic [31:0]     pwdata;
        logic [31:0]     rdata;
        logic            pwrite;
        logic            penable;
        logic            slverr;
        logic            tout;
    } model_t;

    model_t m = '0;

    function automatic model_t model_next(input model_t c);
        model_t          n;
        logic [NREQ-1:0] elig;
        int              i;
        n = c;
        if (PRESET) begin
            n       = '0;
            n.owner = -1;
            n.last  = NREQ - 1;
            return n;
        end
        elig   = REQ & ~c.done;
        n.done = '0;
        if (c.owner < 0) begin
            n.gnt = '0;
            for (int k = 1; k <= NREQ; k++) begin
                i = (c.last + k) % NREQ;
                if (n.owner < 0 && elig[i]) n.owner = i;
            end
            if (n.owner >= 0) begin
                n.last    = n.owner;
                n.age     = 0;
                n.gnt     = NREQ'(1) << n.owner;
                n.paddr   = a_addr[n.owner];
                n.pwdata  = a_wdata[n.owner];
                n.pwrite  = REQ_WRITE[n.owner];
                n.psel    = 16'(1) << n.paddr[27:24];
                n.penable = 1'b0;
            end
        end else if (c.age == 0) begin
            n.age     = 1;
            n.penable = 1'b1;
        end else if (PREADY || c.age == TIMEOUT) begin
            n.done    = c.gnt;
            n.tout    = !PREADY;
            n.slverr  = PREADY ? PSLVERR : 1'b1;
            n.rdata   = (PREADY && !c.pwrite) ? PRDATA : 32'd0;
            n.psel    = '0;
            n.paddr   = '0;
            n.pwdata  = '0;
            n.penable = 1'b0;
            n.owner   = -1;
        end else begin
            n.age = c.age + 1;
        end
        return n;
    endfunction

    always @(posedge PCLK) m <= model_next(m);

    always @(negedge PCLK) begin
        chk("GNT", 32'(GNT), 32'(m.gnt));
        chk("DONE", 32'(DONE), 32'(m.done));
        chk("PSEL", 32'(PSEL), 32'(m.psel));
        chk("PENABLE", 32'(PENABLE), 32'(m.penable));
        chk("PADDR", PADDR, m.paddr);
        chk("PWDATA", PWDATA, m.pwdata);
        if (m.psel != 0) chk("PWRITE", 32'(PWRITE), 32'(m.pwrite));
        if (m.done != 0) begin
            chk("RDATA", RDATA, m.rdata);
            chk("SLVERR", 32'(SLVERR), 32'(m.slverr));
            chk("TOUT", 32'(TOUT), 32'(m.tout));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1);
    end

    task automatic do_reset();
        PRESET = 1'b1;
        REQ    = '0;
        @(negedge PCLK);
        @(negedge PCLK);
        PRESET = 1'b0;
    endtask

    task automatic wait_penable(input string nm);
        int n = 0;
        while (PENABLE !== 1'b1 && n < 20) begin
            @(negedge PCLK);
            n++;
        end
        chk(nm, 32'(n < 20), 32'd1);
    endtask

    task automatic wait_done(input string nm, output int n);
        n = 0;
        do begin
            @(negedge PCLK);
            n++;
        end while (DONE == '0 && n < 20);
        chk(nm, 32'(n < 20), 32'd1);
    endtask

    int n;
    int got;
    int order [5];
    int exp_order [5] = '{0, 1, 2, 3, 0};

    initial begin
        PRESET    = 1'b1;
        REQ       = '0;
        REQ_WRITE = '0;
        PRDATA    = '0;
        PREADY    = 1'b0;
        PSLVERR   = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            a_addr[i]  = '0;
            a_wdata[i] = '0;
        end
        @(negedge PCLK);
        @(negedge PCLK);
        chk("reset GNT", 32'(GNT), 32'd0);
        chk("reset PSEL", 32'(PSEL), 32'd0);
        chk("reset PENABLE", 32'(PENABLE), 32'd0);
        chk("reset RDATA", RDATA, 32'd0);
        PRESET = 1'b0;

        // Single read from requester 2
        @(negedge PCLK);
        a_addr[2] = 32'h0300_0010;
        REQ_WRITE = '0;
        PREADY    = 1'b1;
        PRDATA    = 32'hDEAD_BEEF;
        REQ       = 4'b0100;
        @(negedge PCLK);
        chk("t1 PSEL", 32'(PSEL), 32'h0008);
        chk("t1 GNT", 32'(GNT), 32'h4);
        chk("t1 PADDR", PADDR, 32'h0300_0010);
        @(negedge PCLK);
        chk("t1 PENABLE", 32'(PENABLE), 32'd1);
        @(negedge PCLK);
        chk("t1 DONE", 32'(DONE), 32'h4);
        chk("t1 RDATA", RDATA, 32'hDEAD_BEEF);
        chk("t1 SLVERR", 32'(SLVERR), 32'd0);
        REQ = '0;

        // All requesters continuously active, from reset
        do_reset();
        PREADY = 1'b1;
        REQ    = 4'b1111;
        got = 0;
        n   = 0;
        while (got < 5 && n < 40) begin
            @(negedge PCLK);
            n++;
            if (DONE != '0) begin
                chk("t2 DONE==GNT", 32'(DONE), 32'(GNT));
                order[got] = oh_idx(DONE);
                got++;
            end
        end
        chk("t2 count", 32'(got), 32'd5);
        chk("t2 cycles", 32'(n), 32'd15);
        for (int i = 0; i < 5; i++) chk("t2 order", 32'(order[i]), 32'(exp_order[i]));
        REQ = '0;

        // Write with five wait states and slave error
        @(negedge PCLK);
        PREADY       = 1'b0;
        PSLVERR      = 1'b1;
        a_addr[1]    = 32'h0A00_0044;
        a_wdata[1]   = 32'h1234_5678;
        REQ_WRITE[1] = 1'b1;
        REQ          = 4'b0010;
        wait_penable("t3 wait");
        for (int k = 1; k <= 6; k++) begin
            chk("t3 PADDR", PADDR, 32'h0A00_0044);
            chk("t3 PWDATA", PWDATA, 32'h1234_5678);
            chk("t3 PSEL", 32'(PSEL), 32'h0400);
            chk("t3 DONE early", 32'(DONE), 32'd0);
            if (k == 6) PREADY = 1'b1;
            @(negedge PCLK);
        end
        chk("t3 DONE", 32'(DONE), 32'h2);
        chk("t3 SLVERR", 32'(SLVERR), 32'd1);
        chk("t3 TOUT", 32'(TOUT), 32'd0);
        chk("t3 RDATA", RDATA, 32'd0);
        REQ          = '0;
        REQ_WRITE[1] = 1'b0;
        PSLVERR      = 1'b0;
        @(negedge PCLK);
        chk("t3 DONE once", 32'(DONE), 32'd0);

        // Timeout with PREADY never asserted
        PREADY    = 1'b0;
        PRDATA    = 32'hCAFE_F00D;
        a_addr[3] = 32'h0F00_0000;
        REQ       = 4'b1000;
        wait_penable("t4 wait");
        n = 0;
        while (DONE == '0 && n < 20) begin
            @(negedge PCLK);
            n++;
        end
        chk("t4 latency", 32'(n), 32'd8);
        chk("t4 DONE", 32'(DONE), 32'h8);
        chk("t4 SLVERR", 32'(SLVERR), 32'd1);
        chk("t4 TOUT", 32'(TOUT), 32'd1);
        chk("t4 RDATA", RDATA, 32'd0);
        REQ = '0;

        // Reset pulse in ACCESS
        @(negedge PCLK);
        a_addr[2] = 32'h0500_0000;
        REQ       = 4'b0100;
        wait_penable("t5 wait");
        PRESET = 1'b1;
        REQ    = '0;
        @(negedge PCLK);
        chk("t5 GNT", 32'(GNT), 32'd0);
        chk("t5 DONE", 32'(DONE), 32'd0);
        chk("t5 PSEL", 32'(PSEL), 32'd0);
        chk("t5 PENABLE", 32'(PENABLE), 32'd0);
        chk("t5 PADDR", PADDR, 32'd0);
        chk("t5 TOUT", 32'(TOUT), 32'd0);
        chk("t5 SLVERR", 32'(SLVERR), 32'd0);
        PRESET = 1'b0;
        repeat (3) begin
            @(negedge PCLK);
            chk("t5 no DONE", 32'(DONE), 32'd0);
        end
        PREADY    = 1'b1;
        a_addr[0] = 32'h0100_0020;
        REQ       = 4'b0001;
        wait_done("t5 wait done", n);
        chk("t5 req0 DONE", 32'(DONE), 32'h1);
        chk("t5 req0 latency", 32'(n), 32'd3);
        REQ = '0;

        // Requester 1 withdraws after grant
        @(negedge PCLK);
        PREADY       = 1'b0;
        a_addr[1]    = 32'h0200_0008;
        REQ_WRITE[1] = 1'b1;
        REQ          = 4'b0010;
        n = 0;
        while (GNT[1] !== 1'b1 && n < 20) begin
            @(negedge PCLK);
            n++;
        end
        chk("t6 grant", 32'(GNT), 32'h2);
        REQ = '0;
        @(negedge PCLK);
        PREADY = 1'b1;
        wait_done("t6 wait done", n);
        chk("t6 DONE", 32'(DONE), 32'h2);
        REQ_WRITE[1] = 1'b0;

        // Requester 1 holds REQ through DONE while requester 3 waits
        do_reset();
        PREADY = 1'b1;
        REQ    = 4'b1010;
        wait_done("t7 wait done", n);
        chk("t7 first DONE", 32'(DONE), 32'h2);
        @(negedge PCLK);
        chk("t7 next GNT", 32'(GNT), 32'h8);
        REQ = '0;
        repeat (4) @(negedge PCLK);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            @(negedge PCLK);
            PRESET = ($urandom_range(0, 199) == 0);
            for (int i = 0; i < NREQ; i++) begin
                if (!REQ[i]) begin
                    if ($urandom_range(0, 99) < 30) begin
                        a_addr[i]    = $urandom;
                        a_wdata[i]   = $urandom;
                        REQ_WRITE[i] = 1'($urandom_range(0, 1));
                        REQ[i]       = 1'b1;
                    end
                end else if (DONE[i]) begin
                    if ($urandom_range(0, 99) < 70) REQ[i] = 1'b0;
                end else if ($urandom_range(0, 99) < 3) begin
                    REQ[i] = 1'b0;
                end
            end
            PREADY  = ($urandom_range(0, 99) < 35);
            PRDATA  = $urandom;
            PSLVERR = ($urandom_range(0, 99) < 20);
        end
        @(negedge PCLK);
        PRESET = 1'b0;
        REQ    = '0;
        repeat (20) @(negedge PCLK);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
